// File: rtl/otter_bp_pkg.sv
// Shared types and constants for the OTTER branch target unit.
// Holds the control-flow type encoding and the 2-bit counter state names.
package otter_bp_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_t;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Unconditional jumps start strongly taken; conditional branches only weakly.
  function automatic logic [1:0] alloc_ctr(input br_type_t t);
    return (t == BR_COND) ? CTR_WT : CTR_ST;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating predictor counter.
// init has priority over inc/dec; inc and dec are never expected together.
module bp_sat_counter
  import otter_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  input  logic       dec,
  input  logic       init,
  input  logic [1:0] init_val,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (init) begin
      ctr_next = init_val;
    end else if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else if (dec) begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters for fetch prediction, plus the
// execute-stage resolver that detects mispredicts and trains the BTB.
module branch_target_predictor
  import otter_bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] FETCH_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            EX_VALID,
  input  br_type_t        EX_TYPE,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [XLEN-1:0] EX_IMM,
  input  logic [XLEN-1:0] EX_RS1,
  input  logic            EX_COND,
  input  logic            EX_PRED_TAKEN,
  input  logic [XLEN-1:0] EX_PRED_TARGET,
  output logic            MISPREDICT,
  output logic [XLEN-1:0] REDIRECT_PC
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  // BTB storage, kept in flops so the whole array clears on async reset.
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  br_type_t            type_q   [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;

  assign f_idx = FETCH_PC[IDX_BITS+1:2];
  assign f_tag = FETCH_PC[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign PRED_TAKEN  = f_hit && (ctr_q[f_idx][1] || (type_q[f_idx] != BR_COND));
  assign PRED_TARGET = PRED_TAKEN ? target_q[f_idx] : FETCH_PC + XLEN'(4);

  // ---------------- execute-side resolve ----------------
  logic [XLEN-1:0] ex_sum_rs1;
  logic [XLEN-1:0] ex_target;
  logic            ex_taken;
  logic            ex_is_cf;

  assign ex_sum_rs1 = EX_RS1 + EX_IMM;
  assign ex_is_cf   = EX_VALID && (EX_TYPE != BR_NONE);

  always_comb begin
    ex_taken  = 1'b0;
    ex_target = EX_PC + EX_IMM;
    unique case (EX_TYPE)
      BR_NONE: ex_taken = 1'b0;
      BR_COND: ex_taken = EX_COND;
      BR_JAL:  ex_taken = 1'b1;
      BR_JALR: begin
        ex_taken  = 1'b1;
        ex_target = {ex_sum_rs1[XLEN-1:1], 1'b0};
      end
    endcase
  end

  assign REDIRECT_PC = ex_taken ? ex_target : EX_PC + XLEN'(4);
  assign MISPREDICT  = ex_is_cf &&
                       ((EX_PRED_TAKEN != ex_taken) ||
                        (ex_taken && (EX_PRED_TARGET != ex_target)));

  // ---------------- BTB training ----------------
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic [1:0]          ctr_next;
  logic                wr_en;

  assign ex_idx = EX_PC[IDX_BITS+1:2];
  assign ex_tag = EX_PC[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  bp_sat_counter u_ctr (
    .ctr      (ctr_q[ex_idx]),
    .inc      (ex_hit && ex_taken),
    .dec      (ex_hit && !ex_taken),
    .init     (!ex_hit && ex_taken),
    .init_val (alloc_ctr(EX_TYPE)),
    .ctr_next (ctr_next)
  );

  // Not-taken misses never allocate, so they leave the BTB untouched.
  assign wr_en = ex_is_cf && (ex_hit || ex_taken);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        type_q[i]   <= BR_NONE;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (FLUSH) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= ctr_next;
      if (ex_taken) begin
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        type_q[ex_idx]   <= EX_TYPE;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed plus randomized bench for branch_target_predictor, checked
// against a table-level BTB model held in plain arrays.
module tb_branch_target_predictor;
  import otter_bp_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  br_type_t    ex_type;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_cond;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int pass_cnt = 0;
  int total    = 0;

  branch_target_predictor #(.XLEN(32), .ENTRIES(16), .TAG_BITS(8)) dut (
    .CLK(clk), .RST(rst), .FLUSH(flush),
    .FETCH_PC(fetch_pc), .PRED_TAKEN(pred_taken), .PRED_TARGET(pred_target),
    .EX_VALID(ex_valid), .EX_TYPE(ex_type), .EX_PC(ex_pc), .EX_IMM(ex_imm),
    .EX_RS1(ex_rs1), .EX_COND(ex_cond), .EX_PRED_TAKEN(ex_pred_taken),
    .EX_PRED_TARGET(ex_pred_target), .MISPREDICT(mispredict), .REDIRECT_PC(redirect_pc)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  br_type_t    m_type  [16];
  int          m_ctr   [16];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return (pc / 64) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_hit(pc) && (m_ctr[i] >= 2 || m_type[i] != BR_COND);
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_actual_taken();
    if (ex_type == BR_COND) return ex_cond;
    return (ex_type == BR_JAL) || (ex_type == BR_JALR);
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (ex_type == BR_JALR) begin
      s = ex_rs1 + ex_imm;
      return s - (s % 2);
    end
    return ex_pc + ex_imm;
  endfunction

  function automatic logic [31:0] m_redirect();
    return m_actual_taken() ? m_target() : ex_pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    if (!ex_valid || ex_type == BR_NONE) return 1'b0;
    if (ex_pred_taken != m_actual_taken()) return 1'b1;
    return m_actual_taken() && (ex_pred_target != m_target());
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_type[i] = BR_NONE; m_ctr[i] = 1;
    end
  endtask

  task automatic m_clock();
    int i = idx_of(ex_pc);
    if (flush) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (ex_valid && ex_type != BR_NONE) begin
      if (m_hit(ex_pc)) begin
        if (m_actual_taken()) begin
          m_ctr[i]  = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i]  = m_target();
          m_type[i] = ex_type;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (m_actual_taken()) begin
        m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = m_target();
        m_type[i] = ex_type; m_ctr[i] = (ex_type == BR_COND) ? 2 : 3;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ptaken"},  32'(pred_taken),  32'(m_pred_taken(fetch_pc)));
    check({tag, "_ptarget"}, pred_target,      m_pred_target(fetch_pc));
    check({tag, "_mispred"}, 32'(mispredict),  32'(m_mispredict()));
    check({tag, "_redir"},   redirect_pc,      m_redirect());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input br_type_t t, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input bit cond,
                       input bit pt, input logic [31:0] ptg, input logic [31:0] fpc,
                       input bit fl);
    ex_valid = v; ex_type = t; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_cond = cond;
    ex_pred_taken = pt; ex_pred_target = ptg; fetch_pc = fpc; flush = fl;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle_lookup(input logic [31:0] fpc);
    drive(0, BR_NONE, 0, 0, 0, 0, 0, 0, fpc, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pool [8];
    logic [31:0] pc;
    br_type_t    t;

    rst = 1'b1;
    m_reset();
    idle_lookup(32'h100);
    #12;
    check("rst_ptaken", 32'(pred_taken), 32'd0);
    check("rst_ptarget", pred_target, 32'h104);
    rst = 1'b0;
    edge_step();

    // 1: everything misses after reset
    idle_lookup(32'h100);
    settle("t1");
    check("t1_target", pred_target, 32'h104);
    edge_step();

    // 2: first taken COND allocates
    drive(1, BR_COND, 32'h100, 32'h40, 0, 1, 0, 0, 32'h100, 0);
    settle("t2");
    check("t2_mispred", 32'(mispredict), 32'd1);
    check("t2_redir", redirect_pc, 32'h140);
    edge_step();
    idle_lookup(32'h100);
    settle("t2_lk");
    check("t2_lk_taken", 32'(pred_taken), 32'd1);
    check("t2_lk_target", pred_target, 32'h140);
    edge_step();

    // 3: two not-taken resolves walk the counter down
    drive(1, BR_COND, 32'h100, 32'h40, 0, 0, 1, 32'h140, 32'h100, 0);
    settle("t3a");
    check("t3_mispred", 32'(mispredict), 32'd1);
    check("t3_redir", redirect_pc, 32'h104);
    edge_step();
    drive(1, BR_COND, 32'h100, 32'h40, 0, 0, 0, 0, 32'h100, 0);
    settle("t3b");
    edge_step();
    idle_lookup(32'h100);
    settle("t3_lk");
    check("t3_lk_taken", 32'(pred_taken), 32'd0);
    edge_step();

    // 4: JALR clears bit 0 of the sum
    drive(1, BR_JALR, 32'h200, 32'h10, 32'h2001, 0, 1, 32'h2010, 32'h200, 0);
    settle("t4a");
    check("t4_ok_mispred", 32'(mispredict), 32'd0);
    edge_step();
    drive(1, BR_JALR, 32'h200, 32'h10, 32'h3000, 0, 1, 32'h2010, 32'h200, 0);
    settle("t4b");
    check("t4_bad_mispred", 32'(mispredict), 32'd1);
    check("t4_bad_redir", redirect_pc, 32'h3010);
    edge_step();

    // 5: aliasing on index 0 and same-cycle read of the entry being written
    drive(1, BR_COND, 32'h100, 32'h40, 0, 1, 0, 0, 32'h0, 0);
    settle("t5a");
    edge_step();
    drive(1, BR_COND, 32'h140, 32'h80, 0, 1, 0, 0, 32'h100, 0);
    settle("t5b");
    edge_step();
    idle_lookup(32'h100);
    settle("t5_alias");
    check("t5_alias_taken", 32'(pred_taken), 32'd0);
    edge_step();
    drive(1, BR_JAL, 32'h180, 32'h20, 0, 0, 0, 0, 32'h140, 0);
    settle("t5_same");
    check("t5_old_taken", 32'(pred_taken), 32'd1);
    check("t5_old_target", pred_target, 32'h1C0);
    edge_step();

    // 6: flush beats a concurrent update; async reset acts between edges
    drive(1, BR_JAL, 32'h204, 32'h30, 0, 0, 0, 0, 32'h200, 1);
    settle("t6_fl");
    edge_step();
    idle_lookup(32'h204);
    settle("t6_lk204");
    check("t6_flush_204", 32'(pred_taken), 32'd0);
    edge_step();
    idle_lookup(32'h200);
    settle("t6_lk200");
    check("t6_flush_200", 32'(pred_taken), 32'd0);
    edge_step();
    drive(1, BR_JAL, 32'h300, 32'h100, 0, 0, 0, 0, 32'h300, 0);
    settle("t6_train");
    edge_step();
    idle_lookup(32'h300);
    #1;
    check("t6_pre_rst", 32'(pred_taken), 32'd1);
    #1 rst = 1'b1;
    m_reset();
    #1;
    check("t6_rst_taken", 32'(pred_taken), 32'd0);
    check("t6_rst_target", pred_target, 32'h304);
    rst = 1'b0;
    settle("t6_post");
    edge_step();

    // random traffic over a small PC pool so entries hit, alias and saturate
    for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, 255)) * 4;
    pool[7] = 32'hFFFF_FFFC;
    for (int n = 0; n < 400; n++) begin
      pc = pool[$urandom_range(0, 7)];
      t  = br_type_t'($urandom_range(0, 3));
      drive($urandom_range(0, 5) != 0, t, pc,
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 1023)) * 4
                                         : -(32'($urandom_range(0, 1023)) * 4),
            $urandom, $urandom_range(0, 1) != 0, 0, 0,
            pool[$urandom_range(0, 7)], $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) != 0) begin
        ex_pred_taken  = m_pred_taken(pc);
        ex_pred_target = m_pred_target(pc);
      end else begin
        ex_pred_taken  = $urandom_range(0, 1) != 0;
        ex_pred_target = $urandom;
      end
      settle("rnd");
      edge_step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
